// File: rtl/wave_scheduler.sv
// ============================================================================
// Module   : wave_scheduler
// Purpose  : Spawns enemy waves on frame ticks, tracks survivors, ends the game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_scheduler #(
  parameter int NUM_WAVES        = 3,
  parameter int ENEMIES_PER_WAVE = 8,
  parameter int SPAWN_INTERVAL   = 16,
  parameter int WAVE_PAUSE       = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play,
  input  logic       frame_tick,
  input  logic       kill,
  input  logic       ship_hit,
  output logic       spawn,
  output logic [3:0] spawn_slot,
  output logic [2:0] wave,
  output logic [4:0] alive_count,
  output logic       wave_clear,
  output logic       done,
  output logic       victory
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPAWN  = 3'd1,
    S_FIGHT  = 3'd2,
    S_PAUSE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [7:0] c_spawn_reload = 8'(SPAWN_INTERVAL - 1);
  localparam logic [7:0] c_pause_reload = 8'(WAVE_PAUSE - 1);
  localparam logic [4:0] c_enemies      = 5'(ENEMIES_PER_WAVE);
  localparam logic [2:0] c_last_wave    = 3'(NUM_WAVES - 1);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [4:0] spawned_q, spawned_d;
  logic [4:0] alive_q, alive_d;
  logic [2:0] wave_q, wave_d;
  logic [3:0] spawn_slot_q, spawn_slot_d;
  logic       spawn_q, spawn_d;
  logic       wave_clear_q, wave_clear_d;
  logic       done_q, done_d;
  logic       victory_q, victory_d;

  logic       active_w;
  logic [4:0] spawned_inc_w;

  assign active_w      = (state_q == S_SPAWN) || (state_q == S_FIGHT) || (state_q == S_PAUSE);
  assign spawned_inc_w = spawned_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    spawned_d    = spawned_q;
    alive_d      = alive_q;
    wave_d       = wave_q;
    spawn_slot_d = spawn_slot_q;
    spawn_d      = 1'b0;
    wave_clear_d = 1'b0;
    done_d       = done_q;
    victory_d    = victory_q;

    if (!play) begin
      state_d      = S_IDLE;
      frame_cnt_d  = 8'd0;
      spawned_d    = 5'd0;
      alive_d      = 5'd0;
      wave_d       = 3'd0;
      spawn_slot_d = 4'd0;
      done_d       = 1'b0;
      victory_d    = 1'b0;
    end else if (ship_hit && active_w) begin
      // A hit pre-empts any spawn or clear scheduled for this edge.
      state_d   = S_FINISH;
      done_d    = 1'b1;
      victory_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_SPAWN;
          frame_cnt_d  = 8'd0;
          spawned_d    = 5'd0;
          alive_d      = 5'd0;
          wave_d       = 3'd0;
          spawn_slot_d = 4'd0;
          done_d       = 1'b0;
          victory_d    = 1'b0;
        end
        S_SPAWN: begin
          if (frame_tick && (frame_cnt_q == 8'd0)) begin
            spawn_d      = 1'b1;
            spawn_slot_d = spawned_q[3:0];
            spawned_d    = spawned_inc_w;
            frame_cnt_d  = c_spawn_reload;
            // A simultaneous kill cancels the increment.
            if (!kill) begin
              alive_d = alive_q + 5'd1;
            end
            if (spawned_inc_w == c_enemies) begin
              state_d = S_FIGHT;
            end
          end else begin
            if (frame_tick) begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end
            if (kill && (alive_q != 5'd0)) begin
              alive_d = alive_q - 5'd1;
            end
          end
        end
        S_FIGHT: begin
          if (alive_q == 5'd0) begin
            if (wave_q == c_last_wave) begin
              state_d   = S_FINISH;
              done_d    = 1'b1;
              victory_d = 1'b1;
            end else begin
              state_d      = S_PAUSE;
              wave_clear_d = 1'b1;
              frame_cnt_d  = c_pause_reload;
            end
          end else if (kill) begin
            alive_d = alive_q - 5'd1;
          end
        end
        S_PAUSE: begin
          if (frame_tick) begin
            if (frame_cnt_q == 8'd0) begin
              state_d     = S_SPAWN;
              wave_d      = wave_q + 3'd1;
              spawned_d   = 5'd0;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end
          end
        end
        S_FINISH: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= 8'd0;
      spawned_q    <= 5'd0;
      alive_q      <= 5'd0;
      wave_q       <= 3'd0;
      spawn_slot_q <= 4'd0;
      spawn_q      <= 1'b0;
      wave_clear_q <= 1'b0;
      done_q       <= 1'b0;
      victory_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      spawned_q    <= spawned_d;
      alive_q      <= alive_d;
      wave_q       <= wave_d;
      spawn_slot_q <= spawn_slot_d;
      spawn_q      <= spawn_d;
      wave_clear_q <= wave_clear_d;
      done_q       <= done_d;
      victory_q    <= victory_d;
    end
  end

  assign spawn       = spawn_q;
  assign spawn_slot  = spawn_slot_q;
  assign wave        = wave_q;
  assign alive_count = alive_q;
  assign wave_clear  = wave_clear_q;
  assign done        = done_q;
  assign victory     = victory_q;

endmodule

`default_nettype wire
